mem_bus_arbiter: RTL and testbench

Two-port arbiter that shares the processor's single synchronous memory port between the CPU (fetch/LD/ST address path) and a DMA/loader requester. It accepts level requests, grants one requester at a time (round-robin or fixed CPU priority), sequences the memory access, waits the read latency, and returns a one-cycle acknowledge with registered read data. It sits between the processor datapath/control FSM and the memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr_pick.sv | 19 +
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Requester indices; a pick value of 1 means DMA.
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Wait counter width, enough for read latencies up to 3.
  localparam int CNT_W = 2;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way picker: round-robin or fixed CPU priority on ties.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       pick,
  output logic       any
);

  // Tie goes to the port not granted last, or to the CPU when fixed.
  always_comb begin
    any  = |req;
    pick = req[PORT_DMA];
    if (&req) pick = fixed_prio ? 1'b0 : ~last_grant;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous memory port between the CPU and a DMA requester.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_dma
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

  arb_state_e       state;
  cmd_t             cmd;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             pick;
  logic             any;

  mem_arb_rr_pick u_pick (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .pick       (pick),
    .any        (any)
  );

  // Memory address/data come straight from the command register.
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Grant, strobe the memory once, wait out read latency, pulse ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd        <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_dma    <= 1'b0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            cmd.we     <= pick ? dma_we    : cpu_we;
            cmd.addr   <= pick ? dma_addr  : cpu_addr;
            cmd.wdata  <= pick ? dma_wdata : cpu_wdata;
            gnt_dma    <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= pick ? dma_we : cpu_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (cmd.we) begin
            cpu_ack <= ~gnt_dma;
            dma_ack <= gnt_dma;
            state   <= RESP;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            if (gnt_dma) dma_rdata <= mem_rdata;
            else         cpu_rdata <= mem_rdata;
            cpu_ack <= ~gnt_dma;
            dma_ack <= gnt_dma;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench: two arbiter instances (RD_LAT=1 round-robin, RD_LAT=3
// fixed priority) checked cycle by cycle against a transaction timeline model.
module tb_mem_bus_arbiter;
  localparam int NI = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req   [NI][2];
  logic          we    [NI][2];
  logic [AW-1:0] addr  [NI][2];
  logic [DW-1:0] wdata [NI][2];
  logic          ack   [NI][2];
  logic [DW-1:0] rdata [NI][2];
  logic          busy    [NI];
  logic          mem_en  [NI];
  logic          mem_we  [NI];
  logic          gnt_dma [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wdata [NI];

  // Memory contents are a fixed function of address.
  function automatic logic [DW-1:0] hash(logic [AW-1:0] a);
    return DW'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic int rdl(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RDL = (g == 0) ? 1 : 3;
    logic [DW-1:0] mrd = '0;
    logic [3:0]    en_h = '0;
    logic [AW-1:0] a_h [4];

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .FIXED_PRIO(g)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(req[g][0]), .cpu_we(we[g][0]), .cpu_addr(addr[g][0]), .cpu_wdata(wdata[g][0]),
      .cpu_ack(ack[g][0]), .cpu_rdata(rdata[g][0]),
      .dma_req(req[g][1]), .dma_we(we[g][1]), .dma_addr(addr[g][1]), .dma_wdata(wdata[g][1]),
      .dma_ack(ack[g][1]), .dma_rdata(rdata[g][1]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mrd), .busy(busy[g]), .gnt_dma(gnt_dma[g])
    );

    // Memory: valid data exactly RDL cycles after the strobe, garbage otherwise.
    always @(negedge clk) begin
      for (int k = 3; k > 0; k--) a_h[k] = a_h[k-1];
      a_h[0] = mem_addr[g];
      en_h   = {en_h[2:0], mem_en[g]};
      mrd    = en_h[RDL] ? hash(a_h[RDL]) : DW'($urandom);
    end
  end

  // Reference model: per instance, one transaction timeline.
  bit            have_g [NI];
  int            grant_c[NI], ack_c[NI], idle_c[NI];
  int            owner  [NI];
  int            last   [NI];
  logic          cmd_we [NI];
  logic [AW-1:0] cmd_addr [NI];
  logic [DW-1:0] cmd_wdata[NI];
  logic [DW-1:0] exp_rd [NI][2];
  int  c = 0;
  bit  rand_en = 1'b0;
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", tag, i, c, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      have_g[i] = 1'b0; owner[i] = 0; last[i] = 1;
      cmd_we[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
      exp_rd[i][0] = '0; exp_rd[i][1] = '0;
      grant_c[i] = 0; ack_c[i] = 0; idle_c[i] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      bit e_en, e_busy, e_ack;
      e_en   = have_g[i] && (c == grant_c[i] + 1);
      e_busy = have_g[i] && (c > grant_c[i]) && (c <= ack_c[i]);
      e_ack  = have_g[i] && (c == ack_c[i]);
      if (e_ack && !cmd_we[i]) exp_rd[i][owner[i]] = hash(cmd_addr[i]);
      chk("busy",      i, 32'(busy[i]),      32'(e_busy));
      chk("mem_en",    i, 32'(mem_en[i]),    32'(e_en));
      chk("mem_we",    i, 32'(mem_we[i]),    32'(e_en && cmd_we[i]));
      chk("mem_addr",  i, 32'(mem_addr[i]),  32'(cmd_addr[i]));
      chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(cmd_wdata[i]));
      chk("cpu_ack",   i, 32'(ack[i][0]),    32'(e_ack && owner[i] == 0));
      chk("dma_ack",   i, 32'(ack[i][1]),    32'(e_ack && owner[i] == 1));
      chk("cpu_rdata", i, 32'(rdata[i][0]),  32'(exp_rd[i][0]));
      chk("dma_rdata", i, 32'(rdata[i][1]),  32'(exp_rd[i][1]));
      chk("gnt_dma",   i, 32'(gnt_dma[i]),   32'(owner[i]));
    end
  endtask

  // Requester behaviour, driven by the model's view of grant and ack.
  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit mine, acked, flight;
        mine   = have_g[i] && owner[i] == p;
        acked  = mine && c == ack_c[i];
        flight = mine && c <= ack_c[i];
        if (acked) begin
          if (rand_en && ($urandom % 4 != 0)) req[i][p] = 1'b0;
        end else if (flight) begin
          if (rand_en) begin
            if ($urandom % 2 == 0) begin
              we[i][p] = 1'($urandom); addr[i][p] = AW'($urandom); wdata[i][p] = DW'($urandom);
            end
            if ($urandom % 4 == 0) req[i][p] = 1'b0;
          end
        end else if (req[i][p]) begin
          if (rand_en && ($urandom % 16 == 0)) req[i][p] = 1'b0;
        end else if (rand_en && ($urandom % 3 == 0)) begin
          req[i][p] = 1'b1; we[i][p] = 1'($urandom);
          addr[i][p] = AW'($urandom); wdata[i][p] = DW'($urandom);
        end
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (c >= idle_c[i] && (req[i][0] || req[i][1])) begin
        int w;
        if (req[i][0] && req[i][1]) w = (i == 1) ? 0 : ((last[i] == 1) ? 0 : 1);
        else                        w = req[i][1] ? 1 : 0;
        last[i] = w; owner[i] = w; have_g[i] = 1'b1; grant_c[i] = c;
        cmd_we[i] = we[i][w]; cmd_addr[i] = addr[i][w]; cmd_wdata[i] = wdata[i][w];
        ack_c[i]  = c + 2 + (we[i][w] ? 0 : rdl(i));
        idle_c[i] = ack_c[i] + 1;
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    drive();
    model_step();
    @(negedge clk);
    c++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset(bit keep);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy",   i, 32'(busy[i]),      0);
      chk("rst_en",     i, 32'(mem_en[i]),    0);
      chk("rst_we",     i, 32'(mem_we[i]),    0);
      chk("rst_addr",   i, 32'(mem_addr[i]),  0);
      chk("rst_wdata",  i, 32'(mem_wdata[i]), 0);
      chk("rst_cack",   i, 32'(ack[i][0]),    0);
      chk("rst_dack",   i, 32'(ack[i][1]),    0);
      chk("rst_crdata", i, 32'(rdata[i][0]),  0);
      chk("rst_drdata", i, 32'(rdata[i][1]),  0);
      chk("rst_gnt",    i, 32'(gnt_dma[i]),   0);
      if (!keep) begin req[i][0] = 1'b0; req[i][1] = 1'b0; end
    end
    model_reset();
    @(negedge clk);
    c++;
    reset_n = 1'b1;
    for (int i = 0; i < NI; i++) idle_c[i] = c;
  endtask

  initial begin
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
      end
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Both ports read continuously: reset lands in WAIT, then ties resolve.
    rand_en = 1'b0;
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b1; we[i][p] = 1'b0;
        addr[i][p] = AW'(16'h0010 + p); wdata[i][p] = '0;
      end
    cycle();
    cycle();
    do_reset(1'b1);
    repeat (40) cycle();

    rand_en = 1'b1;
    repeat (1500) cycle();
    do_reset(1'b0);
    repeat (500) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
